// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, opcodes,
// ALU operation codes, immediate formats, datapath selects and trap causes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SLT  = 6'd5;
  localparam logic [5:0] ALU_SLTU = 6'd6;
  localparam logic [5:0] ALU_SLL  = 6'd7;
  localparam logic [5:0] ALU_SRL  = 6'd8;
  localparam logic [5:0] ALU_SRA  = 6'd9;

  // Operation class handed from the sequencer to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_RDATA  = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Maps the sequencer's operation class plus funct3/funct7[5] to an ALU op code.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [5:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] on an I-type is immediate data, so ADDI never becomes SUB
          3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: state register, memory wait counter, sticky
// trap, and per-state decode of every datapath select and write enable.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic [3:0]  mem_w,
  output logic        reg_w,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [5:0]  alu_control,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [1:0]         alu_op;
  logic               is_rtype;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               br_ok, timeout, in_wait;
  logic               unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign br_ok        = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign in_wait      = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // Fires on the last permitted no-ready cycle of a memory wait
  assign timeout      = !mem_ready && (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
  assign trap         = trap_q;
  assign trap_cause   = cause_q;

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (instr[30]),
    .is_rtype    (is_rtype),
    .alu_control (alu_control)
  );

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = (state_q == S_FETCH)   ? S_DECODE :
                    (state_q == S_MEMREAD) ? S_MEMWB  : S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:         state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_JAL:            state_d = S_ALUWB;
      S_MEMWB, S_ALUWB: state_d = S_FETCH;
      S_BRANCH: begin
        if (br_ok) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      default: state_d = S_TRAP;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_wait && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_w      = 4'h0;
    reg_w      = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    is_rtype   = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = timeout ? 4'h0 : 4'hF;
        instr_done = mem_ready;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        is_rtype  = (state_q == S_EXECR);
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        instr_done = br_ok;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset must suppress every write immediately, even while state is still FETCH
    if (srst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_w      = 4'h0;
      reg_w      = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
